// File: rtl/ring_mem_responder.sv
// Ring target node: claims RD/WR requests for NODE_ID, serves them from a
// local word SRAM and returns responses on the rsp ring with 2-cycle latency.
package ring_mem_pkg;
    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_RD     = 3'd1,
        OP_WR     = 3'd2,
        OP_RD_RSP = 3'd3,
        OP_WR_RSP = 3'd4,
        OP_INV    = 3'd5
    } t_opcode;

    typedef struct packed {
        logic [9:0]  requestor;
        t_opcode     opcode;
        logic [31:0] address;
        logic [31:0] data;
    } t_slot;
endpackage

module ring_mem_responder
    import ring_mem_pkg::*;
#(
    parameter logic [7:0] NODE_ID    = 8'hF0,
    parameter int         MEM_DEPTH  = 1024,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic        QClk,
    input  logic        RstQnnnL,
    input  logic        RingReqInValidQ500H,
    input  logic [9:0]  RingReqInRequestorQ500H,
    input  t_opcode     RingReqInOpcodeQ500H,
    input  logic [31:0] RingReqInAddressQ500H,
    input  logic [31:0] RingReqInDataQ500H,
    input  logic        RingRspInValidQ500H,
    input  logic [9:0]  RingRspInRequestorQ500H,
    input  t_opcode     RingRspInOpcodeQ500H,
    input  logic [31:0] RingRspInAddressQ500H,
    input  logic [31:0] RingRspInDataQ500H,
    output logic        RingReqOutValidQ502H,
    output logic [9:0]  RingReqOutRequestorQ502H,
    output t_opcode     RingReqOutOpcodeQ502H,
    output logic [31:0] RingReqOutAddressQ502H,
    output logic [31:0] RingReqOutDataQ502H,
    output logic        RingRspOutValidQ502H,
    output logic [9:0]  RingRspOutRequestorQ502H,
    output t_opcode     RingRspOutOpcodeQ502H,
    output logic [31:0] RingRspOutAddressQ502H,
    output logic [31:0] RingRspOutDataQ502H,
    output logic [15:0] BounceCntQ502H
);
    localparam int IW = $clog2(MEM_DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    t_slot req_in, rsp_in;
    t_slot req_q1, rsp_q1, req_q2, rsp_q2;
    t_slot new_rsp, fifo_head;
    logic  req_v1, rsp_v1, req_v2, rsp_v2;

    logic [31:0]   mem [MEM_DEPTH];
    t_slot         fifo [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [15:0]   bounce_cnt;

    logic          hit, accept, pop, bypass, push, is_wr;
    logic [IW-1:0] idx;

    assign req_in = {RingReqInRequestorQ500H, RingReqInOpcodeQ500H,
                     RingReqInAddressQ500H, RingReqInDataQ500H};
    assign rsp_in = {RingRspInRequestorQ500H, RingRspInOpcodeQ500H,
                     RingRspInAddressQ500H, RingRspInDataQ500H};

    always_comb begin
        idx    = req_q1.address[IW+1:2];
        is_wr  = (req_q1.opcode == OP_WR);
        hit    = req_v1
              && (req_q1.address[31:24] == NODE_ID)
              && (req_q1.opcode == OP_RD || is_wr);
        // Fullness is judged before any same-cycle pop
        accept = hit && (count != FULL);
        pop    = !rsp_v1 && (count != '0);
        bypass = accept && !rsp_v1 && (count == '0);
        push   = accept && !bypass;

        new_rsp.requestor = req_q1.requestor;
        new_rsp.opcode    = is_wr ? OP_WR_RSP : OP_RD_RSP;
        new_rsp.address   = req_q1.address;
        new_rsp.data      = is_wr ? req_q1.data : mem[idx];

        fifo_head = fifo[rd_ptr];
    end

    always_ff @(posedge QClk) begin
        if (accept && is_wr) begin
            mem[idx] <= req_q1.data;
        end
    end

    always_ff @(posedge QClk) begin
        if (push) begin
            fifo[wr_ptr] <= new_rsp;
        end
    end

    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            req_v1     <= 1'b0;
            rsp_v1     <= 1'b0;
            req_q1     <= '0;
            rsp_q1     <= '0;
            req_v2     <= 1'b0;
            rsp_v2     <= 1'b0;
            req_q2     <= '0;
            rsp_q2     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            bounce_cnt <= '0;
        end else begin
            req_v1 <= RingReqInValidQ500H;
            req_q1 <= req_in;
            rsp_v1 <= RingRspInValidQ500H;
            rsp_q1 <= rsp_in;

            if (accept) begin
                req_v2 <= 1'b0;
                req_q2 <= '0;
            end else begin
                req_v2 <= req_v1;
                req_q2 <= req_q1;
            end

            if (rsp_v1) begin
                rsp_v2 <= 1'b1;
                rsp_q2 <= rsp_q1;
            end else if (pop) begin
                rsp_v2 <= 1'b1;
                rsp_q2 <= fifo_head;
            end else if (bypass) begin
                rsp_v2 <= 1'b1;
                rsp_q2 <= new_rsp;
            end else begin
                rsp_v2 <= 1'b0;
                rsp_q2 <= '0;
            end

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end

            if (hit && !accept && bounce_cnt != 16'hFFFF) begin
                bounce_cnt <= bounce_cnt + 16'd1;
            end
        end
    end

    assign RingReqOutValidQ502H     = req_v2;
    assign RingReqOutRequestorQ502H = req_q2.requestor;
    assign RingReqOutOpcodeQ502H    = req_q2.opcode;
    assign RingReqOutAddressQ502H   = req_q2.address;
    assign RingReqOutDataQ502H      = req_q2.data;
    assign RingRspOutValidQ502H     = rsp_v2;
    assign RingRspOutRequestorQ502H = rsp_q2.requestor;
    assign RingRspOutOpcodeQ502H    = rsp_q2.opcode;
    assign RingRspOutAddressQ502H   = rsp_q2.address;
    assign RingRspOutDataQ502H      = rsp_q2.data;
    assign BounceCntQ502H           = bounce_cnt;
endmodule

// File: tb/tb_ring_mem_responder.sv
// Directed bench for ring_mem_responder: claim/forward, ordering, contention,
// index wrap, mid-run reset and bounce-counter saturation.
module tb_ring_mem_responder;
    import ring_mem_pkg::*;

    logic        QClk = 1'b0;
    logic        RstQnnnL;
    logic        req_v, rsp_v;
    logic [9:0]  req_rq, rsp_rq;
    t_opcode     req_op, rsp_op;
    logic [31:0] req_a, req_d, rsp_a, rsp_d;
    logic        ro_v, so_v;
    logic [9:0]  ro_rq, so_rq;
    t_opcode     ro_op, so_op;
    logic [31:0] ro_a, ro_d, so_a, so_d;
    logic [15:0] bcnt;

    logic [77:0] req_obs, rsp_obs;
    int n_cmp = 0;
    int n_bad = 0;

    assign req_obs = {ro_v, ro_rq, ro_op, ro_a, ro_d};
    assign rsp_obs = {so_v, so_rq, so_op, so_a, so_d};

    always #5 QClk = ~QClk;

    ring_mem_responder dut (
        .QClk                     (QClk),
        .RstQnnnL                 (RstQnnnL),
        .RingReqInValidQ500H      (req_v),
        .RingReqInRequestorQ500H  (req_rq),
        .RingReqInOpcodeQ500H     (req_op),
        .RingReqInAddressQ500H    (req_a),
        .RingReqInDataQ500H       (req_d),
        .RingRspInValidQ500H      (rsp_v),
        .RingRspInRequestorQ500H  (rsp_rq),
        .RingRspInOpcodeQ500H     (rsp_op),
        .RingRspInAddressQ500H    (rsp_a),
        .RingRspInDataQ500H       (rsp_d),
        .RingReqOutValidQ502H     (ro_v),
        .RingReqOutRequestorQ502H (ro_rq),
        .RingReqOutOpcodeQ502H    (ro_op),
        .RingReqOutAddressQ502H   (ro_a),
        .RingReqOutDataQ502H      (ro_d),
        .RingRspOutValidQ502H     (so_v),
        .RingRspOutRequestorQ502H (so_rq),
        .RingRspOutOpcodeQ502H    (so_op),
        .RingRspOutAddressQ502H   (so_a),
        .RingRspOutDataQ502H      (so_d),
        .BounceCntQ502H           (bcnt)
    );

    task automatic step();
        @(posedge QClk);
        #1;
    endtask

    task automatic drv_req(input logic v, input logic [9:0] rq,
                           input t_opcode op, input logic [31:0] a,
                           input logic [31:0] d);
        req_v = v; req_rq = rq; req_op = op; req_a = a; req_d = d;
    endtask

    task automatic drv_rsp(input logic v, input logic [9:0] rq,
                           input t_opcode op, input logic [31:0] a,
                           input logic [31:0] d);
        rsp_v = v; rsp_rq = rq; rsp_op = op; rsp_a = a; rsp_d = d;
    endtask

    task automatic idle();
        drv_req(1'b0, '0, OP_NOP, '0, '0);
        drv_rsp(1'b0, '0, OP_NOP, '0, '0);
    endtask

    task automatic test_reset();
        RstQnnnL = 1'b0;
        idle();
        #1;
        n_cmp++;
        if (req_obs !== 78'd0) begin
            n_bad++;
            $display("FAIL reset_req: got %h want 0", req_obs);
        end
        n_cmp++;
        if (rsp_obs !== 78'd0 || bcnt !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_rsp: got %h/%h want 0/0", rsp_obs, bcnt);
        end
        #11 RstQnnnL = 1'b1;
        step();
    endtask

    task automatic test_wr_rd();
        logic [77:0] exp;
        drv_req(1'b1, 10'h012, OP_WR, 32'hF0000010, 32'hDEADBEEF);
        step();
        drv_req(1'b1, 10'h012, OP_RD, 32'hF0000010, 32'h0);
        step();
        idle();
        exp = {1'b1, 10'h012, OP_WR_RSP, 32'hF0000010, 32'hDEADBEEF};
        n_cmp++;
        if (rsp_obs !== exp || req_obs !== 78'd0) begin
            n_bad++;
            $display("FAIL wr_rsp: got %h req %h want %h req 0",
                     rsp_obs, req_obs, exp);
        end
        step();
        exp = {1'b1, 10'h012, OP_RD_RSP, 32'hF0000010, 32'hDEADBEEF};
        n_cmp++;
        if (rsp_obs !== exp || req_obs !== 78'd0) begin
            n_bad++;
            $display("FAIL rd_rsp: got %h req %h want %h req 0",
                     rsp_obs, req_obs, exp);
        end
        step();
    endtask

    task automatic test_pass_through();
        logic [77:0] exp_q, exp_s;
        drv_req(1'b1, 10'h055, OP_RD, 32'h11000000, 32'h00001234);
        drv_rsp(1'b1, 10'h077, OP_RD, 32'hF0000010, 32'hCAFEF00D);
        step();
        drv_req(1'b1, 10'h056, OP_WR, 32'h11000010, 32'h00000099);
        drv_rsp(1'b0, '0, OP_NOP, '0, '0);
        step();
        drv_req(1'b1, 10'h066, OP_RD_RSP, 32'hF0000010, 32'h00000001);
        exp_q = {1'b1, 10'h055, OP_RD, 32'h11000000, 32'h00001234};
        exp_s = {1'b1, 10'h077, OP_RD, 32'hF0000010, 32'hCAFEF00D};
        n_cmp++;
        if (req_obs !== exp_q || rsp_obs !== exp_s) begin
            n_bad++;
            $display("FAIL pass_rd: got %h/%h want %h/%h",
                     req_obs, rsp_obs, exp_q, exp_s);
        end
        step();
        idle();
        exp_q = {1'b1, 10'h056, OP_WR, 32'h11000010, 32'h00000099};
        n_cmp++;
        if (req_obs !== exp_q || so_v !== 1'b0) begin
            n_bad++;
            $display("FAIL pass_wr: got %h rspv %b want %h rspv 0",
                     req_obs, so_v, exp_q);
        end
        step();
        exp_q = {1'b1, 10'h066, OP_RD_RSP, 32'hF0000010, 32'h00000001};
        n_cmp++;
        if (req_obs !== exp_q || so_v !== 1'b0) begin
            n_bad++;
            $display("FAIL pass_op: got %h rspv %b want %h rspv 0",
                     req_obs, so_v, exp_q);
        end
        drv_req(1'b1, 10'h013, OP_RD, 32'hF0000010, 32'h0);
        step();
        idle();
        step();
        exp_s = {1'b1, 10'h013, OP_RD_RSP, 32'hF0000010, 32'hDEADBEEF};
        n_cmp++;
        if (rsp_obs !== exp_s) begin
            n_bad++;
            $display("FAIL pass_mem: got %h want %h", rsp_obs, exp_s);
        end
        step();
    endtask

    task automatic test_wrap();
        logic [77:0] exp;
        drv_req(1'b1, 10'h021, OP_WR, 32'hF000100C, 32'h5A5A1234);
        step();
        drv_req(1'b1, 10'h022, OP_RD, 32'hF000000F, 32'h0);
        step();
        idle();
        step();
        exp = {1'b1, 10'h022, OP_RD_RSP, 32'hF000000F, 32'h5A5A1234};
        n_cmp++;
        if (rsp_obs !== exp) begin
            n_bad++;
            $display("FAIL wrap: got %h want %h", rsp_obs, exp);
        end
        step();
    endtask

    task automatic test_contention();
        logic [77:0] exp_q, exp_s;
        for (int i = 0; i < 7; i++) begin
            if (i < 6) begin
                drv_req(1'b1, 10'h100 + 10'(i), OP_WR,
                        32'hF0000100 + 32'(4 * i), 32'hA0000000 + 32'(i));
                drv_rsp(1'b1, 10'h200 + 10'(i), OP_RD_RSP,
                        32'h33000000 + 32'(i), 32'hC0DE0000 + 32'(i));
            end else begin
                idle();
            end
            step();
            if (i >= 1) begin
                exp_s = {1'b1, 10'h200 + 10'(i - 1), OP_RD_RSP,
                         32'h33000000 + 32'(i - 1), 32'hC0DE0000 + 32'(i - 1)};
                exp_q = (i - 1 < 4) ? 78'd0 :
                        {1'b1, 10'h100 + 10'(i - 1), OP_WR,
                         32'hF0000100 + 32'(4 * (i - 1)),
                         32'hA0000000 + 32'(i - 1)};
                n_cmp++;
                if (req_obs !== exp_q || rsp_obs !== exp_s) begin
                    n_bad++;
                    $display("FAIL cont_slot%0d: got %h/%h want %h/%h",
                             i - 1, req_obs, rsp_obs, exp_q, exp_s);
                end
            end
        end
        n_cmp++;
        if (bcnt !== 16'd2) begin
            n_bad++;
            $display("FAIL cont_bounce: got %0d want 2", bcnt);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            exp_s = {1'b1, 10'h100 + 10'(i), OP_WR_RSP,
                     32'hF0000100 + 32'(4 * i), 32'hA0000000 + 32'(i)};
            n_cmp++;
            if (rsp_obs !== exp_s) begin
                n_bad++;
                $display("FAIL drain%0d: got %h want %h", i, rsp_obs, exp_s);
            end
        end
        step();
        n_cmp++;
        if (so_v !== 1'b0) begin
            n_bad++;
            $display("FAIL drain_idle: got %b want 0", so_v);
        end
    endtask

    task automatic test_reset_mid();
        logic [77:0] exp;
        for (int i = 0; i < 3; i++) begin
            drv_req(1'b1, 10'h300 + 10'(i), OP_WR,
                    32'hF0000200 + 32'(4 * i), 32'hB0000000 + 32'(i));
            drv_rsp(1'b1, 10'h301, OP_RD_RSP, 32'h44000000, 32'h0);
            step();
        end
        drv_req(1'b0, '0, OP_NOP, '0, '0);
        step();
        RstQnnnL = 1'b0;
        idle();
        #1;
        n_cmp++;
        if (req_obs !== 78'd0 || rsp_obs !== 78'd0 || bcnt !== 16'd0) begin
            n_bad++;
            $display("FAIL mid_reset: got %h/%h/%h want 0/0/0",
                     req_obs, rsp_obs, bcnt);
        end
        @(posedge QClk);
        #2 RstQnnnL = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if (so_v !== 1'b0 || ro_v !== 1'b0) begin
                n_bad++;
                $display("FAIL post_reset%0d: got %b/%b want 0/0",
                         i, so_v, ro_v);
            end
        end
        drv_req(1'b1, 10'h031, OP_RD, 32'hF0000208, 32'h0);
        step();
        drv_req(1'b1, 10'h032, OP_RD, 32'hF0000100, 32'h0);
        step();
        idle();
        exp = {1'b1, 10'h031, OP_RD_RSP, 32'hF0000208, 32'hB0000002};
        n_cmp++;
        if (rsp_obs !== exp) begin
            n_bad++;
            $display("FAIL keep_mem_a: got %h want %h", rsp_obs, exp);
        end
        step();
        exp = {1'b1, 10'h032, OP_RD_RSP, 32'hF0000100, 32'hA0000000};
        n_cmp++;
        if (rsp_obs !== exp) begin
            n_bad++;
            $display("FAIL keep_mem_b: got %h want %h", rsp_obs, exp);
        end
        step();
    endtask

    task automatic test_saturation();
        drv_req(1'b1, 10'h3FF, OP_RD, 32'hF0000000, 32'h0);
        drv_rsp(1'b1, 10'h001, OP_WR_RSP, 32'h55000000, 32'h0);
        repeat (11) step();
        n_cmp++;
        if (bcnt !== 16'd6) begin
            n_bad++;
            $display("FAIL sat_early: got %0d want 6", bcnt);
        end
        repeat (65540) step();
        n_cmp++;
        if (bcnt !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL sat_hold: got %h want ffff", bcnt);
        end
        step();
        n_cmp++;
        if (bcnt !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL sat_stick: got %h want ffff", bcnt);
        end
        idle();
        step();
    endtask

    initial begin
        test_reset();
        test_wr_rd();
        test_pass_through();
        test_wrap();
        test_contention();
        test_reset_mid();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
